// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - predict, update and statistics bundle between pipeline and predictor
// Ports (all carried as interface signals):
//   predict: pred_pc -> pred_taken, pred_next_pc, pred_idx
//   update : upd_valid, upd_is_cf, upd_taken, upd_pc, upd_target,
//            upd_pred_next_pc, upd_idx -> upd_mispredict
//   stats  : stats_clear -> cnt_cf, cnt_mispred
// master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 5,
  parameter int CNT_WIDTH  = 32
) ();
  logic [PC_WIDTH-1:0]   pred_pc;
  logic                  pred_taken;
  logic [PC_WIDTH-1:0]   pred_next_pc;
  logic [INDEX_BITS-1:0] pred_idx;

  logic                  upd_valid;
  logic                  upd_is_cf;
  logic                  upd_taken;
  logic [PC_WIDTH-1:0]   upd_pc;
  logic [PC_WIDTH-1:0]   upd_target;
  logic [PC_WIDTH-1:0]   upd_pred_next_pc;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  upd_mispredict;

  logic                  stats_clear;
  logic [CNT_WIDTH-1:0]  cnt_cf;
  logic [CNT_WIDTH-1:0]  cnt_mispred;

  modport master (
    output pred_pc,
    input  pred_taken, pred_next_pc, pred_idx,
    output upd_valid, upd_is_cf, upd_taken, upd_pc, upd_target,
           upd_pred_next_pc, upd_idx,
    input  upd_mispredict,
    output stats_clear,
    input  cnt_cf, cnt_mispred
  );

  modport slave (
    input  pred_pc,
    output pred_taken, pred_next_pc, pred_idx,
    input  upd_valid, upd_is_cf, upd_taken, upd_pc, upd_target,
           upd_pred_next_pc, upd_idx,
    output upd_mispredict,
    input  stats_clear,
    output cnt_cf, cnt_mispred
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB plus 2-bit PHT predictor with static/bimodal/gshare modes
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   bp    - branch_predictor_if.slave: combinational predict port (IF),
//           clocked update port with combinational mispredict (EX),
//           saturating performance counters with synchronous clear
module branch_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 5,
  parameter int HIST_BITS  = 5,
  parameter int MODE       = 2,
  parameter int CNT_WIDTH  = 32
) (
  input logic clk,
  input logic reset,
  branch_predictor_if.slave bp
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TAG_W = PC_WIDTH - INDEX_BITS - 2;

  logic                btb_valid  [DEPTH];
  logic [TAG_W-1:0]    btb_tag    [DEPTH];
  logic [PC_WIDTH-1:0] btb_target [DEPTH];
  logic [1:0]          pht        [DEPTH];
  logic [HIST_BITS-1:0] ghr;
  logic [HIST_BITS-1:0] ghr_next;

  // ---------------- predict (IF, combinational) ----------------
  logic [INDEX_BITS-1:0] pred_pc_index;
  logic [TAG_W-1:0]      pred_pc_tag;
  logic                  btb_hit;

  assign pred_pc_index = bp.pred_pc[INDEX_BITS+1:2];
  assign pred_pc_tag   = bp.pred_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign btb_hit       = btb_valid[pred_pc_index] && (btb_tag[pred_pc_index] == pred_pc_tag);

  always_comb begin
    bp.pred_idx = pred_pc_index;
    if (MODE == 2) begin
      bp.pred_idx = pred_pc_index ^ INDEX_BITS'(ghr);
    end
  end

  // MODE 0 keeps training the tables but never redirects fetch.
  assign bp.pred_taken   = (MODE != 0) && btb_hit && pht[bp.pred_idx][1];
  assign bp.pred_next_pc = bp.pred_taken ? btb_target[pred_pc_index]
                                         : bp.pred_pc + PC_WIDTH'(4);

  // ---------------- resolve (EX, combinational) ----------------
  logic [PC_WIDTH-1:0]   actual_next_pc;
  logic [INDEX_BITS-1:0] upd_pc_index;
  logic [TAG_W-1:0]      upd_pc_tag;
  logic                  cf_update;
  logic                  alias_kill;

  assign actual_next_pc    = bp.upd_taken ? bp.upd_target : bp.upd_pc + PC_WIDTH'(4);
  assign bp.upd_mispredict = bp.upd_valid && (bp.upd_pred_next_pc != actual_next_pc);

  assign upd_pc_index = bp.upd_pc[INDEX_BITS+1:2];
  assign upd_pc_tag   = bp.upd_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign cf_update    = bp.upd_valid && bp.upd_is_cf;
  // A non-control-flow instruction that was redirected hit a stale/aliased BTB
  // entry; drop that entry only when it really belongs to this pc.
  assign alias_kill   = bp.upd_valid && !bp.upd_is_cf && bp.upd_mispredict &&
                        (btb_tag[upd_pc_index] == upd_pc_tag);

  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_next = bp.upd_taken;
    end else begin : g_histn
      assign ghr_next = {ghr[HIST_BITS-2:0], bp.upd_taken};
    end
  endgenerate

  // ---------------- table and history state ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        btb_valid[i] <= 1'b0;
        pht[i]       <= 2'b01;
      end
      ghr <= '0;
    end else if (cf_update) begin
      btb_valid[upd_pc_index] <= 1'b1;
      if (bp.upd_taken) begin
        if (pht[bp.upd_idx] != 2'b11) pht[bp.upd_idx] <= pht[bp.upd_idx] + 2'd1;
      end else begin
        if (pht[bp.upd_idx] != 2'b00) pht[bp.upd_idx] <= pht[bp.upd_idx] - 2'd1;
      end
      ghr <= ghr_next;
    end else if (alias_kill) begin
      btb_valid[upd_pc_index] <= 1'b0;
    end
  end

  // Tag/target payload is qualified by btb_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && cf_update) begin
      btb_tag[upd_pc_index]    <= upd_pc_tag;
      btb_target[upd_pc_index] <= bp.upd_target;
    end
  end

  // ---------------- performance counters ----------------
  always_ff @(posedge clk) begin
    if (reset || bp.stats_clear) begin
      bp.cnt_cf      <= '0;
      bp.cnt_mispred <= '0;
    end else begin
      if (cf_update && (bp.cnt_cf != '1)) begin
        bp.cnt_cf <= bp.cnt_cf + CNT_WIDTH'(1);
      end
      if (bp.upd_mispredict && (bp.cnt_mispred != '1)) begin
        bp.cnt_mispred <= bp.cnt_mispred + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor (bimodal and gshare instances)
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_if #(.PC_WIDTH(32), .INDEX_BITS(5), .CNT_WIDTH(32)) i1 ();
  branch_predictor_if #(.PC_WIDTH(32), .INDEX_BITS(5), .CNT_WIDTH(32)) i2 ();

  branch_predictor #(.PC_WIDTH(32), .INDEX_BITS(5), .HIST_BITS(5), .MODE(1), .CNT_WIDTH(32))
    u1 (.clk(clk), .reset(reset), .bp(i1.slave));
  branch_predictor #(.PC_WIDTH(32), .INDEX_BITS(5), .HIST_BITS(5), .MODE(2), .CNT_WIDTH(32))
    u2 (.clk(clk), .reset(reset), .bp(i2.slave));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input int sel, input logic v, input logic cf, input logic tk,
                     input logic [31:0] pc, input logic [31:0] tgt,
                     input logic [31:0] pnpc, input logic [4:0] idx);
    if (sel == 1) begin
      i1.upd_valid = v; i1.upd_is_cf = cf; i1.upd_taken = tk; i1.upd_pc = pc;
      i1.upd_target = tgt; i1.upd_pred_next_pc = pnpc; i1.upd_idx = idx;
    end else begin
      i2.upd_valid = v; i2.upd_is_cf = cf; i2.upd_taken = tk; i2.upd_pc = pc;
      i2.upd_target = tgt; i2.upd_pred_next_pc = pnpc; i2.upd_idx = idx;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    i1.pred_pc = 32'h40; i1.stats_clear = 1'b0;
    i2.pred_pc = 32'h40; i2.stats_clear = 1'b0;
    upd(1, 0, 0, 0, 0, 0, 0, 0);
    upd(2, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_taken", i1.pred_taken, 1'b0);
    chk("rst_next", i1.pred_next_pc, 32'h44);
    chk("rst_idx", i1.pred_idx, 5'b10000);
    chk("rst_cnt_cf", i1.cnt_cf, 32'd0);
    chk("rst_cnt_mp", i1.cnt_mispred, 32'd0);

    // Bimodal: first taken update mispredicts; same-cycle predict sees old entry
    upd(1, 1, 1, 1, 32'h40, 32'h10, 32'h44, 5'd16);
    chk("upd1_mispred", i1.upd_mispredict, 1'b1);
    chk("same_cycle_taken", i1.pred_taken, 1'b0);
    chk("same_cycle_next", i1.pred_next_pc, 32'h44);
    tick();
    chk("after1_taken", i1.pred_taken, 1'b1);
    chk("after1_next", i1.pred_next_pc, 32'h10);
    upd(1, 1, 1, 1, 32'h40, 32'h10, 32'h10, 5'd16);
    chk("upd2_mispred", i1.upd_mispredict, 1'b0);
    tick();
    upd(1, 0, 0, 0, 0, 0, 0, 0);
    chk("bim_taken", i1.pred_taken, 1'b1);
    chk("bim_next", i1.pred_next_pc, 32'h10);
    chk("bim_cnt_cf", i1.cnt_cf, 32'd2);
    chk("bim_cnt_mp", i1.cnt_mispred, 32'd1);

    // Saturation: two more taken (counter stays 3), then not-taken steps
    upd(1, 1, 1, 1, 32'h40, 32'h10, 32'h10, 5'd16); tick();
    upd(1, 1, 1, 1, 32'h40, 32'h10, 32'h10, 5'd16); tick();
    upd(1, 1, 1, 0, 32'h40, 32'h10, 32'h10, 5'd16);
    chk("nt1_mispred", i1.upd_mispredict, 1'b1);
    tick();
    upd(1, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_3to2_taken", i1.pred_taken, 1'b1);
    upd(1, 1, 1, 0, 32'h40, 32'h10, 32'h10, 5'd16); tick();
    upd(1, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_2to1_taken", i1.pred_taken, 1'b0);
    chk("sat_2to1_next", i1.pred_next_pc, 32'h44);
    upd(1, 1, 1, 0, 32'h40, 32'h10, 32'h44, 5'd16);
    chk("nt3_mispred", i1.upd_mispredict, 1'b0);
    tick();
    upd(1, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_cnt_cf", i1.cnt_cf, 32'd7);
    chk("sat_cnt_mp", i1.cnt_mispred, 32'd3);

    // upd_valid = 0: no mispredict, no counter change
    upd(1, 0, 1, 1, 32'h40, 32'h99, 32'h1234, 5'd16);
    chk("idle_mispred", i1.upd_mispredict, 1'b0);
    tick();
    chk("idle_cnt_cf", i1.cnt_cf, 32'd7);
    chk("idle_cnt_mp", i1.cnt_mispred, 32'd3);

    // Alias invalidation: retrain counter 0 -> 2, then non-branch redirected
    upd(1, 1, 1, 1, 32'h40, 32'h10, 32'h44, 5'd16); tick();
    upd(1, 1, 1, 1, 32'h40, 32'h10, 32'h44, 5'd16); tick();
    upd(1, 0, 0, 0, 0, 0, 0, 0);
    chk("alias_pre_taken", i1.pred_taken, 1'b1);
    upd(1, 1, 0, 0, 32'h40, 32'h0, 32'h10, 5'd16);
    chk("alias_mispred", i1.upd_mispredict, 1'b1);
    tick();
    upd(1, 0, 0, 0, 0, 0, 0, 0);
    chk("alias_next", i1.pred_next_pc, 32'h44);
    chk("alias_taken", i1.pred_taken, 1'b0);
    chk("alias_cnt_cf", i1.cnt_cf, 32'd9);
    chk("alias_cnt_mp", i1.cnt_mispred, 32'd6);

    // stats_clear wins over a concurrent mispredict
    upd(1, 1, 0, 0, 32'h80, 32'h0, 32'h200, 5'd0);
    i1.stats_clear = 1'b1;
    chk("clr_mispred", i1.upd_mispredict, 1'b1);
    tick();
    i1.stats_clear = 1'b0;
    upd(1, 0, 0, 0, 0, 0, 0, 0);
    chk("clr_cnt_cf", i1.cnt_cf, 32'd0);
    chk("clr_cnt_mp", i1.cnt_mispred, 32'd0);

    // Gshare: GHR 0 -> 00001 -> 00011 via two taken updates
    chk("gs_idx_ghr0", i2.pred_idx, 5'b10000);
    upd(2, 1, 1, 1, 32'h100, 32'h20, 32'h20, 5'd0); tick();
    upd(2, 1, 1, 1, 32'h100, 32'h20, 32'h20, 5'd0); tick();
    upd(2, 0, 0, 0, 0, 0, 0, 0);
    chk("gs_idx_ghr3", i2.pred_idx, 5'b10011);
    chk("gs_taken_nobtb", i2.pred_taken, 1'b0);
    upd(2, 1, 1, 1, 32'h100, 32'h20, 32'h20, 5'd0); tick();
    upd(2, 0, 0, 0, 0, 0, 0, 0);
    chk("gs_idx_ghr7", i2.pred_idx, 5'b10111);
    chk("gs_cnt_cf", i2.cnt_cf, 32'd3);

    // Reset during an update: everything returns to reset values
    upd(1, 1, 1, 1, 32'h40, 32'h10, 32'h44, 5'd16); tick();
    upd(1, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_taken", i1.pred_taken, 1'b1);
    upd(1, 1, 1, 1, 32'h40, 32'h10, 32'h44, 5'd16);
    upd(2, 1, 1, 1, 32'h100, 32'h20, 32'h24, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    upd(1, 0, 0, 0, 0, 0, 0, 0);
    upd(2, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_taken", i1.pred_taken, 1'b0);
    chk("midrst_next", i1.pred_next_pc, 32'h44);
    chk("midrst_cnt_cf", i1.cnt_cf, 32'd0);
    chk("midrst_cnt_mp", i1.cnt_mispred, 32'd0);
    chk("midrst_gs_idx", i2.pred_idx, 5'b10000);
    chk("midrst_gs_cnt_mp", i2.cnt_mispred, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch predictor for the 5-stage RISC-V pipeline: BTB plus a 2-bit-counter PHT, selectable static/bimodal/gshare mode.
- Predict port is combinational and is read in IF every cycle.
- Update port is driven from EX and writes tables, global history and performance counters on the clock edge.
- EX uses upd_mispredict as its flush/redirect condition.

Parameters:
PC_WIDTH, 32, instruction address width.
INDEX_BITS, 5, BTB/PHT depth = 2^INDEX_BITS entries, indexed by pc[INDEX_BITS+1:2].
HIST_BITS, 5, global history length; legal range 1..INDEX_BITS.
MODE, 2, prediction mode: 0 = always not-taken, 1 = bimodal (pc index), 2 = gshare (pc index XOR history).
CNT_WIDTH, 32, width of performance counters.

Ports:
clk  in  1  clock.
reset  in  1  synchronous active-high reset.
pred_pc  in  PC_WIDTH  PC currently in IF.
pred_taken  out  1  predicted taken.
pred_next_pc  out  PC_WIDTH  predicted fetch address for next cycle.
pred_idx  out  INDEX_BITS  PHT index used; carried down the pipeline.
upd_valid  in  1  EX holds a valid (non-bubble) instruction.
upd_is_cf  in  1  instruction is a branch/jal/jalr.
upd_taken  in  1  resolved direction (1 for jal/jalr).
upd_pc  in  PC_WIDTH  PC of resolving instruction.
upd_target  in  PC_WIDTH  resolved target.
upd_pred_next_pc  in  PC_WIDTH  pred_next_pc recorded for this instruction in IF.
upd_idx  in  INDEX_BITS  pred_idx recorded for this instruction in IF.
upd_mispredict  out  1  combinational; EX must flush and redirect.
stats_clear  in  1  synchronous clear of performance counters.
cnt_cf  out  CNT_WIDTH  number of control-flow updates.
cnt_mispred  out  CNT_WIDTH  number of mispredictions.

Behaviour:
- Reset (synchronous, active-high):
  - all BTB valid bits 0; all PHT counters 2'b01 (weakly not-taken); GHR 0; cnt_cf = cnt_mispred = 0.
  - Outputs after reset: pred_taken = 0, pred_next_pc = pred_pc+4, upd_mispredict follows its inputs.
- Reset asserted mid-operation overrides any same-cycle update or stats_clear.
- Index and tag:
  - tag = pc[PC_WIDTH-1:INDEX_BITS+2].
  - Bimodal pred_idx = pred_pc[INDEX_BITS+1:2].
  - Gshare pred_idx = that value XOR zero-extended GHR.
  - MODE 0: pred_idx = pc bits.
- BTB hit: entry at pred_pc[INDEX_BITS+1:2] is valid and its tag equals pred_pc's tag.
- Prediction (zero latency):
  - pred_taken = (MODE != 0) and hit and PHT[pred_idx][1].
  - pred_next_pc = pred_taken ? BTB target : pred_pc+4; addition is modulo 2^PC_WIDTH.
- Mispredict (combinational):
  - actual = upd_taken ? upd_target : upd_pc+4.
  - upd_mispredict = upd_valid and (upd_pred_next_pc != actual).
- Clock-edge update, when upd_valid and upd_is_cf:
  - BTB[upd_pc index] <= {valid = 1, tag(upd_pc), upd_target}.
  - PHT[upd_idx] saturating counter: increment if taken, max 3; decrement if not, min 0.
  - GHR <= {GHR[HIST_BITS-2:0], upd_taken}; for HIST_BITS = 1, GHR <= upd_taken.
  - cnt_cf increments.
- Clock-edge update, when upd_valid and !upd_is_cf and upd_mispredict (BTB alias predicted taken on a non-branch):
  - BTB entry at upd_pc index is invalidated if its tag matches upd_pc.
  - PHT and GHR unchanged.
- cnt_mispred increments on every upd_mispredict.
- Counters saturate at all-ones (no wrap).
- stats_clear zeroes both counters and wins over a same-cycle increment; tables and GHR are untouched.
- Same-cycle read and write of one entry: the predict port sees the pre-edge (old) value; the new value is visible the next cycle.
- upd_valid = 0: no state change, upd_mispredict = 0.
- MODE 0: tables still update (for statistics), but pred_taken is always 0.

Test Plan:
- Reset, then pred_pc = 0x40 → pred_taken = 0, pred_next_pc = 0x44, counters 0.
- MODE 1: two taken updates for upd_pc = 0x40, target 0x10 (upd_pred_next_pc = 0x44) → upd_mispredict = 1 on the first update only; then pred_pc = 0x40 → pred_taken = 1, pred_next_pc = 0x10; cnt_cf = 2, cnt_mispred = 1.
- Counter saturation: four taken then one not-taken at the same index → counter 3 then 2, still predicts taken; two further not-taken → predicts not-taken.
- MODE 2: GHR = 5'b00011, pred_pc = 0x40 (pc bits 5'b10000) → pred_idx = 5'b10011; taken update shifts GHR to 5'b00111.
- Alias: BTB entry for 0x40 target 0x10; upd_valid, !upd_is_cf, upd_pc = 0x40, upd_pred_next_pc = 0x10 → upd_mispredict = 1, entry invalidated, next pred_next_pc = 0x44.
- Edge cases:
  - Update and predict of the same pc in one cycle → prediction uses the old entry.
  - stats_clear concurrent with a mispredict → both counters read 0.
  - reset during an update → all state at reset values.
